// File: rtl/fwperiph_dma_wb_target_mem.sv
// rtl/fwperiph_dma_wb_target_mem.sv - Wishbone target memory with wait states, byte lanes and transfer counters
// Optional feature: FWPERIPH_DMA_WB_TARGET_MEM_RANGE_CHK_EN (out-of-window accesses end with t_err)
module fwperiph_dma_wb_target_mem #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_LOG2  = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] t_adr,
  input  logic [DATA_WIDTH-1:0] t_dat_w,
  output logic [DATA_WIDTH-1:0] t_dat_r,
  input  logic                  t_cyc,
  input  logic                  t_stb,
  input  logic                  t_we,
  input  logic [3:0]            t_sel,
  output logic                  t_ack,
  output logic                  t_err,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_GAP
  } state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic                    we_q;
  logic [3:0]              sel_q;
  logic [DATA_WIDTH-1:0]   dat_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    req;
  logic                    in_idle;
  logic                    commit;
  logic [ADDR_WIDTH-1:0]   cur_adr;
  logic                    cur_we;
  logic [3:0]              cur_sel;
  logic [DATA_WIDTH-1:0]   cur_dat;
  logic [ADDR_WIDTH-1:0]   offset;
  logic [DEPTH_LOG2-1:0]   idx;
  logic                    bad;

  assign req     = t_cyc & t_stb;
  assign in_idle = (state == S_IDLE);

  // With no wait states the transfer commits straight out of IDLE, so the
  // live bus fields are used; otherwise the values latched in IDLE are used.
  always_comb begin
    cur_adr = adr_q;
    cur_we  = we_q;
    cur_sel = sel_q;
    cur_dat = dat_q;
    if (in_idle) begin
      cur_adr = t_adr;
      cur_we  = t_we;
      cur_sel = t_sel;
      cur_dat = t_dat_w;
    end
  end

  // Commit marks the edge that enters RESP; the reset_n term keeps a
  // transfer that is in flight when reset arrives from touching memory.
  always_comb begin
    commit = 1'b0;
    if (reset_n) begin
      if (in_idle && req && (WAIT_STATES == 0))
        commit = 1'b1;
      else if ((state == S_WAIT) && t_cyc && (cnt == 4'd1))
        commit = 1'b1;
    end
  end

  // Word index relative to the window base; subtraction wraps modulo 2^ADDR_WIDTH.
  always_comb begin
    offset = cur_adr - BASE_ADDR;
    idx    = DEPTH_LOG2'(offset >> 2);
  end

`ifdef FWPERIPH_DMA_WB_TARGET_MEM_RANGE_CHK_EN
  // Out of window when below the base or past the last word.
  always_comb begin
    bad = (cur_adr < BASE_ADDR) || ((offset >> (DEPTH_LOG2 + 2)) != '0);
  end
`else
  // Without range checking the index simply wraps inside the array.
  always_comb begin
    bad = 1'b0;
  end
`endif

  // Bus FSM with registered ack/err, read data and transfer counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      adr_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      dat_q    <= '0;
      t_ack    <= 1'b0;
      t_err    <= 1'b0;
      t_dat_r  <= '0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      t_ack <= 1'b0;
      t_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            adr_q <= t_adr;
            we_q  <= t_we;
            sel_q <= t_sel;
            dat_q <= t_dat_w;
            if (WAIT_STATES == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT_STATES);
            end
          end
        end
        S_WAIT: begin
          if (!t_cyc) begin
            state <= S_IDLE;
          end else if (cnt == 4'd1) begin
            state <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: state <= S_GAP;
        S_GAP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (commit) begin
        t_ack <= ~bad;
        t_err <= bad;
        if (!bad) begin
          if (cur_we) begin
            wr_count <= wr_count + 32'd1;
          end else begin
            rd_count <= rd_count + 32'd1;
            t_dat_r  <= mem[idx];
          end
        end
      end
    end
  end

  // Byte-lane memory write on the commit edge; contents are never reset.
  always_ff @(posedge clock) begin
    if (commit && cur_we && !bad) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_sel[b])
          mem[idx][8*b +: 8] <= cur_dat[8*b +: 8];
      end
    end
  end

endmodule
